// File: rtl/mmio_peripheral_pkg.sv
// mmio_peripheral_pkg
//   Shared definitions for the memory-mapped peripheral block: the word
//   offsets of the register map and the bit positions inside TCON.
//   Imported by mmio_timer and mmio_peripheral.
package mmio_peripheral_pkg;

  // Word offset inside the 32-byte window (addr[4:2]).
  typedef logic [2:0] offset_t;

  localparam offset_t OFF_TH      = 3'd0;
  localparam offset_t OFF_TL      = 3'd1;
  localparam offset_t OFF_TCON    = 3'd2;
  localparam offset_t OFF_LED     = 3'd3;
  localparam offset_t OFF_DIGI    = 3'd4;
  localparam offset_t OFF_SYSTICK = 3'd5;

  // TCON layout: enable, interrupt enable, interrupt status.
  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;
  localparam int unsigned TCON_W  = 3;

  localparam int unsigned LED_W  = 8;
  localparam int unsigned DIGI_W = 12;

  // Byte address to register word offset; the byte lane bits are ignored.
  function automatic offset_t word_offset(input logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer
//   Programmable reload timer with interrupt status.
//   TL counts up while TCON.EN is set. When TL is all ones the next edge
//   reloads it from TH and, if TCON.IE is set, latches TCON.ST. irq is the
//   registered status bit.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   wdata    in   store data shared by all three registers
//   we_th    in   write strobe for TH
//   we_tl    in   write strobe for TL
//   we_tcon  in   write strobe for TCON
//   th       out  reload register
//   tl       out  counter register
//   tcon     out  {status, irq enable, enable}
//   irq      out  interrupt request (TCON.ST)
module mmio_timer
  import mmio_peripheral_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       wdata,
  input  logic              we_th,
  input  logic              we_tl,
  input  logic              we_tcon,
  output logic [31:0]       th,
  output logic [31:0]       tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irq
);

  logic              overflow;
  logic              ovf_set;
  logic [31:0]       th_next;
  logic [31:0]       tl_next;
  logic [TCON_W-1:0] tcon_next;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    overflow  = 1'b0;
    ovf_set   = 1'b0;
    th_next   = th;
    tl_next   = tl;
    tcon_next = tcon;

    // Overflow and its status set are judged on the pre-write TCON, so a
    // store to TCON in the overflow cycle cannot mask the event.
    overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    ovf_set  = overflow && tcon[TCON_IE];

    if (we_th) begin
      th_next = wdata;
    end

    // A software write to TL beats both increment and reload. The reload
    // source is the registered TH, i.e. the value before any same-cycle write.
    if (we_tl) begin
      tl_next = wdata;
    end else if (tcon[TCON_EN]) begin
      tl_next = overflow ? th : tl + 32'd1;
    end

    if (we_tcon) begin
      tcon_next = wdata[TCON_W-1:0];
    end
    // Set wins over a same-cycle software clear so no interrupt is lost.
    tcon_next[TCON_ST] = tcon_next[TCON_ST] | ovf_set;
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset has priority over everything, so a store landing in the reset cycle is dropped.
    if (reset) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      th   <= th_next;
      tl   <= tl_next;
      tcon <= tcon_next;
    end
  end

  assign irq = tcon[TCON_ST];

endmodule

// File: rtl/mmio_peripheral.sv
// mmio_peripheral
//   Memory-mapped peripheral slave sitting beside the data memory in the
//   MEM stage. Decodes a 32-byte window at BASE_ADDR and hosts the timer,
//   the LED and seven-segment registers and a free-running systick counter.
//   Reads are combinational so a load completes in its MEM cycle; writes
//   commit at the clock edge.
//
//   Register map (word offset = addr[4:2]):
//     0 TH   1 TL   2 TCON   3 LED[7:0]   4 DIGI[11:0]   5 SYSTICK (RO)
//     6, 7 read as zero, writes ignored.
//
// Parameters
//   BASE_ADDR  window base, must be 32-byte aligned
//   SYSTICK_W  systick width (1..32), zero-extended on read
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   addr       in   MEM-stage byte address
//   wdata      in   store data
//   mem_read   in   load in MEM stage
//   mem_write  in   store in MEM stage
//   sel        out  address lies in the window (combinational)
//   rdata      out  read data, zero unless a load hits the window
//   irq        out  timer interrupt request
//   led        out  LED register
//   digi       out  {anode[3:0], seg[7:0]} display register
module mmio_peripheral
  import mmio_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned SYSTICK_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              sel,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi
);

  offset_t              offset;
  logic                 wr_en;
  logic                 we_th;
  logic                 we_tl;
  logic                 we_tcon;
  logic                 we_led;
  logic                 we_digi;
  logic [SYSTICK_W-1:0] systick;
  logic [31:0]          systick_ext;
  logic [31:0]          th;
  logic [31:0]          tl;
  logic [TCON_W-1:0]    tcon;
  logic                 unused_addr_lsb;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  assign sel    = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset = word_offset(addr);
  assign wr_en  = mem_write && sel;

  assign we_th   = wr_en && (offset == OFF_TH);
  assign we_tl   = wr_en && (offset == OFF_TL);
  assign we_tcon = wr_en && (offset == OFF_TCON);
  assign we_led  = wr_en && (offset == OFF_LED);
  assign we_digi = wr_en && (offset == OFF_DIGI);

  // Byte-lane bits carry no meaning for word registers.
  assign unused_addr_lsb = ^addr[1:0];

  // ---------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------
  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wdata   (wdata),
    .we_th   (we_th),
    .we_tl   (we_tl),
    .we_tcon (we_tcon),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  // ---------------------------------------------------------------------
  // LED, DIGI and systick registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (we_led) begin
        led <= wdata[LED_W-1:0];
      end
      if (we_digi) begin
        digi <= wdata[DIGI_W-1:0];
      end
    end
  end

  // Free-running; wraps naturally at 2^SYSTICK_W. Stores to its offset are
  // not decoded into a strobe, so it can never be disturbed by software.
  always_ff @(posedge clk) begin
    if (reset) begin
      systick <= '0;
    end else begin
      systick <= systick + 1'b1;
    end
  end

  always_comb begin
    systick_ext                = '0;
    systick_ext[SYSTICK_W-1:0] = systick;
  end

  // ---------------------------------------------------------------------
  // Read mux: zero unless a load hits the window, so the MEM/WB mux can
  // OR or select freely.
  // ---------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (mem_read && sel) begin
      case (offset)
        OFF_TH:      rdata = th;
        OFF_TL:      rdata = tl;
        OFF_TCON:    rdata[TCON_W-1:0] = tcon;
        OFF_LED:     rdata[LED_W-1:0]  = led;
        OFF_DIGI:    rdata[DIGI_W-1:0] = digi;
        OFF_SYSTICK: rdata = systick_ext;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_peripheral.sv
// tb_mmio_peripheral
//   Self-checking bench for mmio_peripheral: table-driven bus vectors plus
//   hand-written timer and reset sequences. Expected read data goes through
//   a scoreboard queue pushed at drive time and popped at sample time.
module tb_mmio_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED  = BASE + 32'h0C;
  localparam logic [31:0] A_DIGI = BASE + 32'h10;
  localparam logic [31:0] A_TICK = BASE + 32'h14;
  localparam logic [31:0] A_R6   = BASE + 32'h18;
  localparam logic [31:0] A_R7   = BASE + 32'h1C;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        sel;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  led;
  logic [11:0] digi;

  mmio_peripheral dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .sel       (sel),
    .rdata     (rdata),
    .irq       (irq),
    .led       (led),
    .digi      (digi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset deasserted: the value SYSTICK must show.
  logic [31:0] tick_model = '0;
  always @(posedge clk) begin
    if (reset) tick_model <= '0;
    else       tick_model <= tick_model + 32'd1;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] want;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_sel;
    logic [31:0] exp_rdata;
    logic        tick;       // expected rdata is the current systick
    logic [7:0]  exp_led;
    logic [11:0] exp_digi;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t item;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: empty queue, got %h", act);
    end else begin
      item = sb_q.pop_front();
      check(item.name, act, item.want);
    end
  endtask

  // One bus cycle: drive at the falling edge, sample combinational outputs
  // shortly after, the rising edge then commits any store.
  task automatic bus(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic exp_sel,
                     input logic [31:0] exp_rd, input string nm);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    sb_q.push_back('{nm, exp_rd});
    #2;
    check({nm, ".sel"}, 32'(sel), 32'(exp_sel));
    sb_pop(rdata);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic s, input logic [31:0] r,
                              input logic t, input logic [7:0] l, input logic [11:0] g);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.exp_sel = s; v.exp_rdata = r;
    v.tick = t; v.exp_led = l; v.exp_digi = g;
    return v;
  endfunction

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t        v;
      logic [31:0] want;
      v = vecs[i];
      // tick_model is stable between edges, so it matches SYSTICK in the
      // cycle the vector is applied.
      @(negedge clk);
      want = v.tick ? tick_model : v.exp_rdata;
      mem_read  = v.rd;
      mem_write = v.wr;
      addr      = v.a;
      wdata     = v.d;
      sb_q.push_back('{$sformatf("%s%0d.rdata", tag, i), want});
      #2;
      check($sformatf("%s%0d.sel", tag, i), 32'(sel), 32'(v.exp_sel));
      sb_pop(rdata);
      check($sformatf("%s%0d.led", tag, i), 32'(led), 32'(v.exp_led));
      check($sformatf("%s%0d.digi", tag, i), 32'(digi), 32'(v.exp_digi));
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset.led",  32'(led),  32'h0);
    check("reset.digi", 32'(digi), 32'h0);
    check("reset.irq",  32'(irq),  32'h0);

    // ---- Reset values of every offset, window edges ----
    vecs.push_back(mk(1, 0, A_TH,            0, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, A_TL,            0, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, A_TCON,          0, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, A_LED,           0, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, A_DIGI,          0, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, A_TICK,          0, 1, 0, 1, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, A_R6,            0, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, A_R7,            0, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, 32'h4000_0020,   0, 0, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, 32'h0000_0010,   0, 0, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, 32'h3FFF_FFFC,   0, 0, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(1, 0, BASE + 32'h17,   0, 1, 0, 1, 8'h00, 12'h000));
    vecs.push_back(mk(0, 0, A_TICK,          0, 1, 0, 0, 8'h00, 12'h000));
    run_vecs("rst");

    // ---- LED / DIGI stores, ignored stores, readback ----
    vecs.push_back(mk(0, 1, A_LED,  32'h0000_01A5, 1, 0, 0, 8'h00, 12'h000));
    vecs.push_back(mk(0, 1, A_DIGI, 32'h0FFF_F3C0, 1, 0, 0, 8'hA5, 12'h000));
    vecs.push_back(mk(0, 1, A_TICK, 32'h1234_5678, 1, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_LED,  0, 1, 32'h0000_00A5, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_DIGI, 0, 1, 32'h0000_03C0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_TICK, 0, 1, 0, 1, 8'hA5, 12'h3C0));
    vecs.push_back(mk(0, 1, A_R6,   32'hFFFF_FFFF, 1, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(0, 1, A_R7,   32'hFFFF_FFFF, 1, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(0, 1, 32'h0000_000C, 32'h55, 0, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(0, 1, 32'h4000_002C, 32'h66, 0, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 1, 32'h4000_0020, 32'h77, 0, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_TH,   0, 1, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_TL,   0, 1, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_TCON, 0, 1, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_R6,   0, 1, 0, 0, 8'hA5, 12'h3C0));
    vecs.push_back(mk(1, 0, A_TICK, 0, 1, 0, 1, 8'hA5, 12'h3C0));
    run_vecs("io");

    // ---- Timer: count, overflow, reload, irq latency ----
    bus(0, 1, A_TH,   32'hFFFF_FFFC, 1, 0, "w_th");
    bus(0, 1, A_TL,   32'hFFFF_FFFE, 1, 0, "w_tl");
    bus(0, 1, A_TCON, 32'h0000_0003, 1, 0, "w_tcon");
    bus(1, 0, A_TL, 0, 1, 32'hFFFF_FFFE, "tl_first");
    check("irq_before", 32'(irq), 32'h0);
    bus(1, 0, A_TL, 0, 1, 32'hFFFF_FFFF, "tl_ovf");
    check("irq_ovf_cycle", 32'(irq), 32'h0);
    bus(1, 0, A_TL, 0, 1, 32'hFFFF_FFFC, "tl_reload");
    check("irq_rise", 32'(irq), 32'h1);
    bus(1, 0, A_TCON, 0, 1, 32'h0000_0007, "tcon_pending");
    check("th_kept_irq", 32'(irq), 32'h1);

    // ---- Clear of a pending interrupt outside an overflow ----
    bus(0, 1, A_TCON, 32'h0000_0003, 1, 0, "clr1");
    check("clr1_irq_same", 32'(irq), 32'h1);
    bus(1, 0, A_TCON, 0, 1, 32'h0000_0003, "clr1_tcon");
    check("clr1_irq_drop", 32'(irq), 32'h0);
    // TL was all ones during that read, so status is set again.
    bus(0, 0, A_TL, 0, 1, 0, "idle_ovf2");
    check("ovf2_irq", 32'(irq), 32'h1);

    // ---- Clear landing exactly in an overflow cycle: set wins ----
    bus(1, 0, A_TL, 0, 1, 32'hFFFF_FFFD, "tl_d");
    bus(1, 0, A_TL, 0, 1, 32'hFFFF_FFFE, "tl_e");
    bus(0, 1, A_TCON, 32'h0000_0003, 1, 0, "clr2_in_ovf");
    bus(1, 0, A_TCON, 0, 1, 32'h0000_0007, "clr2_tcon");
    check("clr2_irq_stays", 32'(irq), 32'h1);

    // ---- Software TL write beats increment ----
    bus(0, 1, A_TL, 32'h0000_0010, 1, 0, "w_tl_sw");
    bus(1, 0, A_TL, 0, 1, 32'h0000_0010, "tl_sw");
    bus(0, 1, A_TL, 32'hFFFF_FFFE, 1, 0, "w_tl_near");

    // ---- Reset mid-count with a store in the same cycle ----
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = A_LED; wdata = 32'h77;
    @(negedge clk);
    reset = 1'b0; mem_write = 1'b0;
    #1;
    check("mid_rst.led",  32'(led),  32'h0);
    check("mid_rst.digi", 32'(digi), 32'h0);
    check("mid_rst.irq",  32'(irq),  32'h0);
    bus(1, 0, A_TH,   0, 1, 0, "mid_rst.th");
    bus(1, 0, A_TL,   0, 1, 0, "mid_rst.tl");
    check("mid_rst.irq1", 32'(irq), 32'h0);
    bus(1, 0, A_TCON, 0, 1, 0, "mid_rst.tcon");
    bus(1, 0, A_LED,  0, 1, 0, "mid_rst.ledr");
    bus(1, 0, A_DIGI, 0, 1, 0, "mid_rst.digir");
    check("mid_rst.irq2", 32'(irq), 32'h0);
    bus(1, 0, A_TL,   0, 1, 0, "mid_rst.tl_stopped");
    bus(1, 0, A_TICK, 0, 1, tick_model + 32'd1, "mid_rst.tick");
    check("mid_rst.irq3", 32'(irq), 32'h0);

    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: %0d entries left", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
